// File: rtl/controlador_pkg.sv
`default_nettype none
// ============================================================================
// Module  : controlador_pkg
// Purpose : State encoding and transaction-type constants for the cashier
//           session sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
package controlador_pkg;

  localparam logic [6:0] c_ST_IDLE         = 7'b000_0001;
  localparam logic [6:0] c_ST_ESPERA_PIN   = 7'b000_0010;
  localparam logic [6:0] c_ST_ESPERA_TIPO  = 7'b000_0100;
  localparam logic [6:0] c_ST_ESPERA_MONTO = 7'b000_1000;
  localparam logic [6:0] c_ST_EJECUTAR     = 7'b001_0000;
  localparam logic [6:0] c_ST_CIERRE       = 7'b010_0000;
  localparam logic [6:0] c_ST_BLOQUEADO    = 7'b100_0000;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

  typedef enum logic [6:0] {
    IDLE         = c_ST_IDLE,
    ESPERA_PIN   = c_ST_ESPERA_PIN,
    ESPERA_TIPO  = c_ST_ESPERA_TIPO,
    ESPERA_MONTO = c_ST_ESPERA_MONTO,
    EJECUTAR     = c_ST_EJECUTAR,
    CIERRE       = c_ST_CIERRE,
    BLOQUEADO    = c_ST_BLOQUEADO
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/contador_timeout.sv
`default_nettype none
// ============================================================================
// Module  : contador_timeout
// Purpose : Saturating wait counter; expira flags TIMEOUT_CYC-1 idle cycles.
// Rev     : 1.0 - initial release
// ============================================================================
module contador_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expira
);

  localparam int             c_W   = $clog2(TIMEOUT_CYC);
  localparam logic [c_W-1:0] c_MAX = c_W'(TIMEOUT_CYC - 1);

  logic [c_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != c_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expira = (r_cnt == c_MAX);

endmodule
`default_nettype wire

// File: rtl/controlador_transaccion.sv
`default_nettype none
// ============================================================================
// Module  : controlador_transaccion
// Purpose : Cashier session sequencer: card, PIN verdict, type, amount, execute.
// Rev     : 1.0 - initial release
// ============================================================================
module controlador_transaccion #(
  parameter int BALANCE_W   = 64,
  parameter int MONTO_W     = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tarjeta_recibida,
  input  logic                 pin_ok,
  input  logic                 pin_bloqueo,
  input  logic                 tipo_stb,
  input  logic                 tipo_trans,
  input  logic                 monto_stb,
  input  logic [MONTO_W-1:0]   monto,
  input  logic                 balance_load,
  input  logic [BALANCE_W-1:0] balance_inicial,
  output logic                 pin_habilitar,
  output logic                 ocupado,
  output logic [BALANCE_W-1:0] balance,
  output logic                 balance_actualizado,
  output logic                 entregar_dinero,
  output logic                 fondos_insuficientes,
  output logic                 tiempo_agotado,
  output logic                 bloqueado,
  output logic                 fin
);
  import controlador_pkg::*;

  estado_t              r_estado, w_estado_sig;
  logic                 r_tipo;
  logic [MONTO_W-1:0]   r_monto;
  logic [BALANCE_W-1:0] r_balance, w_balance_sig;
  logic                 r_pin_hab, r_ocupado, r_act, r_ent, r_fondos, r_tout, r_bloq, r_fin;
  logic                 w_act, w_ent, w_fondos, w_tout, w_fin;
  logic                 w_clr, w_en, w_expira;
  logic [BALANCE_W-1:0] w_monto_ext;
  logic [BALANCE_W:0]   w_suma;

  // The counter runs only while waiting for a user strobe; a strobe restarts it
  // so the next wait state starts from zero.
  assign w_en  = ((r_estado == ESPERA_TIPO)  && !tipo_stb) ||
                 ((r_estado == ESPERA_MONTO) && !monto_stb);
  assign w_clr = !((r_estado == ESPERA_TIPO) || (r_estado == ESPERA_MONTO)) ||
                 ((r_estado == ESPERA_TIPO) && tipo_stb);

  contador_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_contador_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_clr),
    .en     (w_en),
    .expira (w_expira)
  );

  assign w_monto_ext = BALANCE_W'(r_monto);
  assign w_suma      = {1'b0, r_balance} + {1'b0, w_monto_ext};

  always_comb begin
    w_estado_sig  = r_estado;
    w_balance_sig = r_balance;
    w_act         = 1'b0;
    w_ent         = 1'b0;
    w_fondos      = 1'b0;
    w_tout        = 1'b0;
    w_fin         = 1'b0;
    case (r_estado)
      IDLE: begin
        if (balance_load)     w_balance_sig = balance_inicial;
        if (tarjeta_recibida) w_estado_sig  = ESPERA_PIN;
      end
      ESPERA_PIN: begin
        if (pin_bloqueo)      w_estado_sig = BLOQUEADO;
        else if (pin_ok)      w_estado_sig = ESPERA_TIPO;
      end
      ESPERA_TIPO: begin
        if (tipo_stb) begin
          w_estado_sig = ESPERA_MONTO;
        end else if (w_expira) begin
          w_estado_sig = IDLE;
          w_tout       = 1'b1;
        end
      end
      ESPERA_MONTO: begin
        if (monto_stb) begin
          w_estado_sig = EJECUTAR;
        end else if (w_expira) begin
          w_estado_sig = IDLE;
          w_tout       = 1'b1;
        end
      end
      EJECUTAR: begin
        w_estado_sig = CIERRE;
        w_fin        = 1'b1;
        if (r_monto != '0) begin
          if (r_tipo == TIPO_DEPOSITO) begin
            w_balance_sig = w_suma[BALANCE_W] ? '1 : w_suma[BALANCE_W-1:0];
            w_act         = 1'b1;
          end else if (w_monto_ext <= r_balance) begin
            w_balance_sig = r_balance - w_monto_ext;
            w_act         = 1'b1;
            w_ent         = 1'b1;
          end else begin
            w_fondos      = 1'b1;
          end
        end
      end
      CIERRE:    w_estado_sig = IDLE;
      BLOQUEADO: w_estado_sig = BLOQUEADO;
      default:   w_estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado  <= IDLE;
      r_tipo    <= 1'b0;
      r_monto   <= '0;
      r_balance <= '0;
      r_pin_hab <= 1'b0;
      r_ocupado <= 1'b0;
      r_act     <= 1'b0;
      r_ent     <= 1'b0;
      r_fondos  <= 1'b0;
      r_tout    <= 1'b0;
      r_bloq    <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
      r_estado  <= w_estado_sig;
      r_balance <= w_balance_sig;
      if ((r_estado == ESPERA_TIPO) && tipo_stb)   r_tipo  <= tipo_trans;
      if ((r_estado == ESPERA_MONTO) && monto_stb) r_monto <= monto;
      // Levels follow the state being entered so they align with it.
      r_pin_hab <= (w_estado_sig == ESPERA_PIN);
      r_ocupado <= (w_estado_sig != IDLE);
      r_bloq    <= (w_estado_sig == BLOQUEADO);
      r_act     <= w_act;
      r_ent     <= w_ent;
      r_fondos  <= w_fondos;
      r_tout    <= w_tout;
      r_fin     <= w_fin;
    end
  end

  assign pin_habilitar        = r_pin_hab;
  assign ocupado              = r_ocupado;
  assign balance              = r_balance;
  assign balance_actualizado  = r_act;
  assign entregar_dinero      = r_ent;
  assign fondos_insuficientes = r_fondos;
  assign tiempo_agotado       = r_tout;
  assign bloqueado            = r_bloq;
  assign fin                  = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_controlador_transaccion.sv
`default_nettype none
// ============================================================================
// Module  : tb_controlador_transaccion
// Purpose : Directed scoreboard bench for the cashier session sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_controlador_transaccion;

  localparam int BW = 64;
  localparam int MW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tarjeta_recibida = 1'b0, pin_ok = 1'b0, pin_bloqueo = 1'b0;
  logic          tipo_stb = 1'b0, tipo_trans = 1'b0, monto_stb = 1'b0, balance_load = 1'b0;
  logic [MW-1:0] monto = '0;
  logic [BW-1:0] balance_inicial = '0;
  logic          pin_habilitar, ocupado, balance_actualizado, entregar_dinero;
  logic          fondos_insuficientes, tiempo_agotado, bloqueado, fin;
  logic [BW-1:0] balance;

  controlador_transaccion #(
    .BALANCE_W   (BW),
    .MONTO_W     (MW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .tarjeta_recibida     (tarjeta_recibida),
    .pin_ok               (pin_ok),
    .pin_bloqueo          (pin_bloqueo),
    .tipo_stb             (tipo_stb),
    .tipo_trans           (tipo_trans),
    .monto_stb            (monto_stb),
    .monto                (monto),
    .balance_load         (balance_load),
    .balance_inicial      (balance_inicial),
    .pin_habilitar        (pin_habilitar),
    .ocupado              (ocupado),
    .balance              (balance),
    .balance_actualizado  (balance_actualizado),
    .entregar_dinero      (entregar_dinero),
    .fondos_insuficientes (fondos_insuficientes),
    .tiempo_agotado       (tiempo_agotado),
    .bloqueado            (bloqueado),
    .fin                  (fin)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0] bal;
    logic          act, ent, fon, tout, fin;
    int            stamp;
    int            id;
  } exp_t;

  exp_t sbq[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Monitor: any result pulse is a DUT response and must match the queue head.
  always @(posedge clk) begin
    #1;
    if (fin || tiempo_agotado || entregar_dinero || balance_actualizado || fondos_insuficientes) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event at cyc %0d: fin=%b tout=%b ent=%b act=%b fon=%b expected none",
                 cyc, fin, tiempo_agotado, entregar_dinero, balance_actualizado, fondos_insuficientes);
      end else begin
        e_mon = sbq.pop_front();
        chk($sformatf("ev%0d_cycle", e_mon.id), BW'(cyc), BW'(e_mon.stamp));
        chk($sformatf("ev%0d_balance", e_mon.id), balance, e_mon.bal);
        chk($sformatf("ev%0d_actualizado", e_mon.id), BW'(balance_actualizado), BW'(e_mon.act));
        chk($sformatf("ev%0d_entregar", e_mon.id), BW'(entregar_dinero), BW'(e_mon.ent));
        chk($sformatf("ev%0d_fondos", e_mon.id), BW'(fondos_insuficientes), BW'(e_mon.fon));
        chk($sformatf("ev%0d_timeout", e_mon.id), BW'(tiempo_agotado), BW'(e_mon.tout));
        chk($sformatf("ev%0d_fin", e_mon.id), BW'(fin), BW'(e_mon.fin));
      end
    end
  end

  // Every task starts and ends on a falling edge with its strobe released.
  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [BW-1:0] v);
    balance_load = 1'b1; balance_inicial = v; nxt(1); balance_load = 1'b0;
  endtask

  task automatic do_card();
    tarjeta_recibida = 1'b1; nxt(1); tarjeta_recibida = 1'b0;
  endtask

  task automatic do_pin(input logic ok, input logic blq);
    pin_ok = ok; pin_bloqueo = blq; nxt(1); pin_ok = 1'b0; pin_bloqueo = 1'b0;
  endtask

  task automatic do_tipo(input logic t);
    tipo_trans = t; tipo_stb = 1'b1; nxt(1); tipo_stb = 1'b0;
  endtask

  task automatic do_monto(input logic [MW-1:0] m);
    monto = m; monto_stb = 1'b1; nxt(1); monto_stb = 1'b0;
  endtask

  task automatic expect_ev(input int id, input int stamp, input logic [BW-1:0] bal,
                           input logic act, input logic ent, input logic fon,
                           input logic tout, input logic f);
    exp_t e;
    e.id = id; e.stamp = stamp; e.bal = bal;
    e.act = act; e.ent = ent; e.fon = fon; e.tout = tout; e.fin = f;
    sbq.push_back(e);
  endtask

  // Full session up to execution; result expected two edges after the amount strobe.
  task automatic session(input int id, input logic t, input logic [MW-1:0] m,
                         input logic [BW-1:0] bal, input logic act, input logic ent,
                         input logic fon);
    do_card();
    do_pin(1'b1, 1'b0);
    do_tipo(t);
    expect_ev(id, cyc + 2, bal, act, ent, fon, 1'b0, 1'b1);
    do_monto(m);
    nxt(3);
    chk($sformatf("s%0d_ocupado_after", id), BW'(ocupado), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nxt(3);
    reset = 1'b0;
    chk("rst_ocupado", BW'(ocupado), '0);
    chk("rst_balance", balance, '0);
    chk("rst_pin_hab", BW'(pin_habilitar), '0);
    chk("rst_bloqueado", BW'(bloqueado), '0);

    // 1: withdrawal 300 from 1000
    do_load(BW'(1000));
    chk("t1_load", balance, BW'(1000));
    do_card();
    chk("t1_pin_hab", BW'(pin_habilitar), BW'(1));
    chk("t1_ocupado", BW'(ocupado), BW'(1));
    do_pin(1'b1, 1'b0);
    chk("t1_pin_hab_off", BW'(pin_habilitar), '0);
    do_tipo(1'b1);
    expect_ev(1, cyc + 2, BW'(700), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    do_monto(32'd300);
    nxt(3);
    chk("t1_ocupado_after", BW'(ocupado), '0);
    chk("t1_balance_after", balance, BW'(700));

    // 2: load and card in the same cycle, then insufficient funds
    balance_load = 1'b1; balance_inicial = BW'(100); tarjeta_recibida = 1'b1;
    nxt(1);
    balance_load = 1'b0; tarjeta_recibida = 1'b0;
    chk("t2_load_with_card", balance, BW'(100));
    chk("t2_pin_hab", BW'(pin_habilitar), BW'(1));
    do_pin(1'b1, 1'b0);
    do_tipo(1'b1);
    expect_ev(2, cyc + 2, BW'(100), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    do_monto(32'd101);
    nxt(3);

    // withdrawal equal to balance empties it
    do_load(BW'(50));
    session(3, 1'b1, 32'd50, '0, 1'b1, 1'b1, 1'b0);

    // 3: deposit saturation, then zero-amount withdrawal
    do_load(64'hFFFF_FFFF_FFFF_FFFA);
    session(4, 1'b0, 32'd10, '1, 1'b1, 1'b0, 1'b0);
    session(5, 1'b1, 32'd0, '1, 1'b0, 1'b0, 1'b0);
    session(6, 1'b0, 32'd5, '1, 1'b1, 1'b0, 1'b0);

    // 5: timeout in ESPERA_TIPO
    do_card();
    expect_ev(7, cyc + 1 + TO, '1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_pin(1'b1, 1'b0);
    nxt(TO + 1);
    chk("t5_ocupado_after_timeout", BW'(ocupado), '0);

    // tipo_stb on the expiry cycle wins; then let ESPERA_MONTO time out
    do_card();
    do_pin(1'b1, 1'b0);
    nxt(TO - 1);
    expect_ev(8, cyc + 1 + TO, '1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_tipo(1'b0);
    chk("t5_ocupado_in_monto", BW'(ocupado), BW'(1));
    nxt(TO + 1);
    chk("t5_ocupado_after_monto_timeout", BW'(ocupado), '0);

    // 4: simultaneous pin_ok and pin_bloqueo locks the card
    do_card();
    do_pin(1'b1, 1'b1);
    chk("t4_bloqueado", BW'(bloqueado), BW'(1));
    chk("t4_pin_hab_off", BW'(pin_habilitar), '0);
    do_card();
    do_load(BW'(5));
    do_tipo(1'b1);
    do_monto(32'd1);
    nxt(3);
    chk("t4_balance_kept", balance, '1);
    chk("t4_bloqueado_sticky", BW'(bloqueado), BW'(1));
    chk("t4_ocupado", BW'(ocupado), BW'(1));
    reset = 1'b1; nxt(1); reset = 1'b0;
    chk("t4_reset_bloqueado", BW'(bloqueado), '0);
    chk("t4_reset_balance", balance, '0);
    chk("t4_reset_ocupado", BW'(ocupado), '0);

    // 6: reset in ESPERA_MONTO aborts with no pulses
    do_load(BW'(1234));
    do_card();
    do_pin(1'b1, 1'b0);
    do_tipo(1'b1);
    reset = 1'b1; nxt(1); reset = 1'b0;
    chk("t6_reset_balance", balance, '0);
    chk("t6_reset_ocupado", BW'(ocupado), '0);
    chk("t6_reset_pin_hab", BW'(pin_habilitar), '0);
    do_monto(32'd7);
    nxt(4);
    chk("t6_idle_monto_ignored", BW'(ocupado), '0);
    chk("t6_balance_zero", balance, '0);

    chk("scoreboard_drained", BW'(sbq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
